// File: rtl/vae_reparam_sampler_if.sv
// Handshake bundle around the reparameterisation sampler: encoder-side mu/logvar,
// noise-generator enable/eps, and decoder-side z.
interface vae_reparam_sampler_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mu;
    logic [DATA_W-1:0] logvar;
    logic              gauss_en;
    logic [DATA_W-1:0] eps;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] z;

    modport slave (
        input  in_valid, mu, logvar, eps, out_ready,
        output in_ready, gauss_en, out_valid, z
    );

    modport master (
        output in_valid, mu, logvar, eps, out_ready,
        input  in_ready, gauss_en, out_valid, z
    );
endinterface

// File: rtl/vae_reparam_sampler.sv
// VAE reparameterisation z = mu + exp(logvar/2)*eps, Q4.12, one sample in flight.
// Latency: out_valid 4 edges after accept; holds z under backpressure, in_ready only in IDLE.
module vae_reparam_sampler #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 12,
    parameter int LOG2E_HALF = 2955
) (
    input  logic                 clk,
    input  logic                 rst,
    vae_reparam_sampler_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    // Largest exponent whose shifted 13-bit mantissa still fits below the sign bit
    localparam int SHMAX  = DATA_W - FRAC_W - 2;
    localparam logic signed [DATA_W-1:0] L2E     = DATA_W'(LOG2E_HALF);
    localparam logic        [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic        [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] ZMAX    = PROD_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] ZMIN    = -ZMAX - PROD_W'(1);

    typedef enum logic [2:0] {IDLE, DRAW, LATCH, EXP, MUL, OUT} state_t;

    state_t                    state_q;
    logic                      in_ready_q, gauss_en_q, out_valid_q;
    logic signed [DATA_W-1:0]  mu_q, logvar_q, eps_q;
    logic signed [PROD_W-1:0]  t_q;
    logic        [DATA_W-1:0]  sigma_q, z_q;

    logic signed [PROD_W-1:0]  lprod, t_d, k, nk, sprod, scaled, s;
    logic        [FRAC_W:0]    mant;
    logic        [DATA_W-1:0]  sigma_d, z_d;

    always_comb begin
        lprod = PROD_W'(logvar_q) * PROD_W'(L2E);
        t_d   = lprod >>> FRAC_W;

        // 2^t ~= 2^k * (1 + f), linear between integer exponents
        k    = t_q >>> FRAC_W;
        nk   = -k;
        mant = {1'b1, t_q[FRAC_W-1:0]};
        if (k > SHMAX)
            sigma_d = POS_MAX;
        else if (k >= 0)
            sigma_d = DATA_W'(mant) << k;
        else
            sigma_d = DATA_W'(mant >> nk);

        sprod  = PROD_W'($signed({1'b0, sigma_q})) * PROD_W'(eps_q);
        scaled = sprod >>> FRAC_W;
        s      = PROD_W'(mu_q) + scaled;
        if (s > ZMAX)
            z_d = POS_MAX;
        else if (s < ZMIN)
            z_d = NEG_MIN;
        else
            z_d = s[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            gauss_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mu_q        <= '0;
            logvar_q    <= '0;
            eps_q       <= '0;
            t_q         <= '0;
            sigma_q     <= '0;
            z_q         <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    mu_q       <= $signed(bus.mu);
                    logvar_q   <= $signed(bus.logvar);
                    in_ready_q <= 1'b0;
                    gauss_en_q <= 1'b1;
                    state_q    <= DRAW;
                end
                DRAW: begin
                    gauss_en_q <= 1'b0;
                    state_q    <= LATCH;
                end
                // generator output has settled one edge after the draw request
                LATCH: begin
                    eps_q   <= $signed(bus.eps);
                    t_q     <= t_d;
                    state_q <= EXP;
                end
                EXP: begin
                    sigma_q <= sigma_d;
                    state_q <= MUL;
                end
                MUL: begin
                    z_q         <= z_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    gauss_en_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.gauss_en  = gauss_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
endmodule

// File: tb/tb_vae_reparam_sampler.sv
// Directed vector bench for vae_reparam_sampler with a behavioural noise generator.
module tb_vae_reparam_sampler;
    logic clk = 1'b0;
    logic rst = 1'b0;

    vae_reparam_sampler_if #(.DATA_W(16)) sif ();

    vae_reparam_sampler dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mu;
        logic [15:0] logvar;
        logic [15:0] eps;
        logic [15:0] z_exp;
    } vec_t;

    vec_t        vecs [7];
    int          total = 0;
    int          bad   = 0;
    int          gcnt  = 0;
    logic [15:0] eps_next = 16'h0000;

    // Registered noise source: new value appears on the edge that samples gauss_en
    always @(posedge clk) begin
        if (!rst) begin
            sif.eps <= 16'h0000;
        end else if (sif.gauss_en) begin
            sif.eps <= eps_next;
            gcnt    <= gcnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_sample(input vec_t v, input int hold);
        int cyc;
        int g0;
        @(negedge clk);
        eps_next      = v.eps;
        sif.mu        = v.mu;
        sif.logvar    = v.logvar;
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b0;
        g0 = gcnt;
        chk("in_ready_idle", 32'(sif.in_ready), 32'd1);
        @(posedge clk);
        #1 sif.in_valid = 1'b0;
        cyc = 0;
        while (!sif.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd4);
        chk("z", 32'(sif.z), 32'(v.z_exp));
        chk("in_ready_busy", 32'(sif.in_ready), 32'd0);
        if (hold > 0) begin
            sif.in_valid = 1'b1;
            sif.mu       = 16'h1234;
            sif.logvar   = 16'h4321;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("bp_z_stable", 32'(sif.z), 32'(v.z_exp));
                chk("bp_out_valid", 32'(sif.out_valid), 32'd1);
                chk("bp_in_ready", 32'(sif.in_ready), 32'd0);
                chk("bp_gauss_en", 32'(sif.gauss_en), 32'd0);
            end
            sif.in_valid = 1'b0;
        end
        @(negedge clk);
        sif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("out_valid_drop", 32'(sif.out_valid), 32'd0);
        chk("in_ready_back", 32'(sif.in_ready), 32'd1);
        chk("gauss_pulses", 32'(gcnt - g0), 32'd1);
        sif.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1000, 16'h0000, 16'h0C00, 16'h1C00};
        vecs[1] = '{16'h0000, 16'h2000, 16'hF400, 16'hDD5F};
        vecs[2] = '{16'h7000, 16'h7FFF, 16'h0C00, 16'h7FFF};
        vecs[3] = '{16'h1000, 16'h8000, 16'h0C00, 16'h103A};
        vecs[4] = '{16'h9000, 16'h7FFF, 16'h8000, 16'h8000};
        vecs[5] = '{16'h0000, 16'h1000, 16'h1000, 16'h1B8B};
        vecs[6] = '{16'hF000, 16'hE000, 16'h1000, 16'hF63A};

        sif.in_valid  = 1'b0;
        sif.mu        = 16'h0000;
        sif.logvar    = 16'h0000;
        sif.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(sif.in_ready), 32'd1);
        chk("rst_gauss_en", 32'(sif.gauss_en), 32'd0);
        chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_z", 32'(sif.z), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 7; i++)
            run_sample(vecs[i], 0);

        run_sample(vecs[1], 10);

        // Abort a sample while it is in the multiply stage
        @(negedge clk);
        eps_next     = 16'h0C00;
        sif.mu       = 16'h2000;
        sif.logvar   = 16'h0000;
        sif.in_valid = 1'b1;
        @(posedge clk);
        #1 sif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(sif.out_valid), 32'd0);
        chk("abort_z", 32'(sif.z), 32'd0);
        chk("abort_gauss_en", 32'(sif.gauss_en), 32'd0);
        chk("abort_in_ready", 32'(sif.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_output", 32'(sif.out_valid), 32'd0);
        chk("abort_idle", 32'(sif.in_ready), 32'd1);

        run_sample(vecs[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
